count_seq_checker: RTL
======================

Name: count_seq_checker

Overview:
- Downstream monitor for the free-running binary counter stage.
- Samples the counter value on qualified cycles and checks that each sample is exactly previous+1 mod 2^WIDTH.
- Locks onto the sequence, then reports wrap-arounds and sequence errors through pulses, a sticky flag and saturating statistics counters.
- Sits between the counter and status/debug logic.

Parameters:
- WIDTH, 3, counter width; cnt_in is WIDTH bits.
- RESYNC_GOOD, 4, consecutive good steps needed to enter LOCKED; legal range 1..15.
- ERR_CNT_W, 8, width of err_count.
- WRAP_CNT_W, 16, width of wrap_count.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset; all state and outputs clear while rst==0.
- cnt_valid  input  1  cnt_in is sampled on this cycle.
- cnt_in  input  WIDTH  counter value (Q2..Q0 concatenated, MSB first, for WIDTH=3).
- clr  input  1  synchronous clear of statistics.
- locked  output  1  state==LOCKED.
- wrap_pulse  output  1  one-cycle pulse on a legal wrap (all-ones to 0) while locked.
- err_pulse  output  1  one-cycle pulse on a sequence error while locked.
- err_sticky  output  1  set on any error; cleared only by clr or rst.
- err_count  output  ERR_CNT_W  saturating error count.
- wrap_count  output  WRAP_CNT_W  saturating wrap count.

Behaviour:
- Reset (rst==0, async): state=IDLE, prev=0, good_run=0, all outputs 0.
- All outputs are registered. Pulses appear the cycle after the sample edge (latency 1).
- cnt_valid==0: hold state, prev and good_run. Pulses are 0.
- expected = prev+1, truncated to WIDTH bits; all-ones wraps to 0.
- IDLE, on valid: prev<=cnt_in, good_run<=0, go to ACQ.
- ACQ, on valid: prev<=cnt_in.
  - Match: good_run++. When good_run+1 == RESYNC_GOOD, go to LOCKED and clear good_run.
  - Mismatch: good_run<=0.
  - No error or wrap reporting in ACQ.
- LOCKED, on valid: prev<=cnt_in.
  - Match: stay in LOCKED. If cnt_in==0, pulse wrap_pulse and increment wrap_count.
  - Mismatch: pulse err_pulse, set err_sticky, increment err_count, go to ACQ with good_run=0. locked drops the next cycle.
- Saturation: both counters stop at all-ones; no rollover.
- clr (sync): zeroes err_count, wrap_count and err_sticky. Does not affect state, prev or locked.
- clr in the same cycle as an event: clear first, then apply the event. Result is count=1, and err_sticky=1 for an error.
- rst asserted mid-operation: immediate clear; re-acquisition starts from IDLE.

Optional Feature:
- Macro: CNT_RESTART_OK_EN.
- Defined: in LOCKED, cnt_in==0 with expected!=0 is a legal counter restart (upstream synchronous reset).
  - No err_pulse, no wrap_pulse, no count change.
  - State stays LOCKED; prev<=0.
- Undefined: that case is a normal sequence error.

Decomposition:
- Package cnt_chk_pkg:
  - State enum, 2-bit: IDLE=0, ACQ=1, LOCKED=2.
  - Default width constants.
- Sub-module sat_counter (parameter W; ports clk, rst, clr, inc, q):
  - clr-then-inc ordering; saturates at all-ones.
  - Instantiated twice, for err_count and wrap_count.

Test Plan:
- Reset, then valid every cycle with 0,1,2,...,7,0,1 (RESYNC_GOOD=4) -> locked=1 the cycle after sample value 4; wrap_pulse one cycle after sample 0; wrap_count=1; err_count=0.
- Locked, sequence 1,2,5,6,7,0,1 -> err_pulse once after 5, err_count=1, err_sticky=1, locked=0. Relocks after 4 good steps (after sample 1); no wrap counted at the 0 seen during ACQ.
- Locked, 3, valid=0 for 3 cycles with cnt_in=6, then valid 4 -> no error, locked stays 1.
- ERR_CNT_W=2, RESYNC_GOOD=1, inject 5 errors, each followed by one good step -> err_count saturates at 3, err_pulse seen 5 times.
- clr alone -> counts and sticky = 0, locked unchanged. clr coincident with an error -> err_count=1, err_sticky=1.
- rst low mid-run -> outputs 0 asynchronously; after release 0..4 relocks.
- With CNT_RESTART_OK_EN: locked, 3,4,0,1 -> no error, locked stays 1, wrap_count unchanged. Without it: err_count=1.

Source files
------------

// File: rtl/cnt_chk_pkg.sv
// Shared types and default sizing for the counter sequence checker.
package cnt_chk_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACQ    = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int unsigned DEF_WIDTH       = 3;
   localparam int unsigned DEF_RESYNC_GOOD = 4;
   localparam int unsigned DEF_ERR_CNT_W   = 8;
   localparam int unsigned DEF_WRAP_CNT_W  = 16;

   // good_run never exceeds 14, since RESYNC_GOOD is at most 15
   localparam int unsigned RUN_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// A clear and an increment in the same cycle yield a count of one.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] r_q;
   logic [W-1:0] w_base;

   assign w_base = clr ? '0 : r_q;
   assign q      = r_q;

   // clear first, then count the event unless already at all-ones
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q <= '0;
      end else if (inc && (w_base != '1)) begin
         r_q <= w_base + W'(1);
      end else begin
         r_q <= w_base;
      end
   end

endmodule

// File: rtl/count_seq_checker.sv
// Monitors a free-running binary counter: locks onto the +1 sequence,
// then reports wrap-arounds and sequence errors.
// Optional macro CNT_RESTART_OK_EN: while locked, a sample of 0 where a
// non-zero value was expected is accepted as an upstream restart.
module count_seq_checker
   import cnt_chk_pkg::*;
#(
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned RESYNC_GOOD = DEF_RESYNC_GOOD,
   parameter int unsigned ERR_CNT_W   = DEF_ERR_CNT_W,
   parameter int unsigned WRAP_CNT_W  = DEF_WRAP_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cnt_valid,
   input  logic [WIDTH-1:0]      cnt_in,
   input  logic                  clr,
   output logic                  locked,
   output logic                  wrap_pulse,
   output logic                  err_pulse,
   output logic                  err_sticky,
   output logic [ERR_CNT_W-1:0]  err_count,
   output logic [WRAP_CNT_W-1:0] wrap_count
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] w_prev_nxt;
   logic [WIDTH-1:0] w_expected;
   logic [RUN_W-1:0] r_good_run;
   logic [RUN_W-1:0] w_good_run_nxt;
   logic [RUN_W-1:0] w_run_inc;
   logic             w_match;
   logic             w_restart;
   logic             w_wrap_ev;
   logic             w_err_ev;
   logic             r_wrap_pulse;
   logic             r_err_pulse;
   logic             r_err_sticky;

   assign w_expected = r_prev + WIDTH'(1);
   assign w_run_inc  = r_good_run + RUN_W'(1);
   assign w_match    = (cnt_in == w_expected);

`ifdef CNT_RESTART_OK_EN
   assign w_restart  = (cnt_in == '0) && (w_expected != '0);
`else
   assign w_restart  = 1'b0;
`endif

   // next-state, sample tracking and event detection
   always_comb begin
      w_state_nxt    = r_state;
      w_prev_nxt     = r_prev;
      w_good_run_nxt = r_good_run;
      w_wrap_ev      = 1'b0;
      w_err_ev       = 1'b0;
      if (cnt_valid) begin
         w_prev_nxt = cnt_in;
         case (r_state)
            IDLE: begin
               w_good_run_nxt = '0;
               w_state_nxt    = ACQ;
            end
            ACQ: begin
               if (w_match) begin
                  if (w_run_inc == RUN_W'(RESYNC_GOOD)) begin
                     w_state_nxt    = LOCKED;
                     w_good_run_nxt = '0;
                  end else begin
                     w_good_run_nxt = w_run_inc;
                  end
               end else begin
                  w_good_run_nxt = '0;
               end
            end
            LOCKED: begin
               if (w_match) begin
                  w_wrap_ev = (cnt_in == '0);
               end else if (!w_restart) begin
                  w_err_ev       = 1'b1;
                  w_state_nxt    = ACQ;
                  w_good_run_nxt = '0;
               end
            end
            default: begin
               w_state_nxt    = IDLE;
               w_good_run_nxt = '0;
            end
         endcase
      end
   end

   // state, sample history, registered pulses and sticky error flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_prev       <= '0;
         r_good_run   <= '0;
         r_wrap_pulse <= 1'b0;
         r_err_pulse  <= 1'b0;
         r_err_sticky <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_prev       <= w_prev_nxt;
         r_good_run   <= w_good_run_nxt;
         r_wrap_pulse <= w_wrap_ev;
         r_err_pulse  <= w_err_ev;
         r_err_sticky <= w_err_ev | (r_err_sticky & ~clr);
      end
   end

   sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (w_err_ev),
      .q   (err_count)
   );

   sat_counter #(.W(WRAP_CNT_W)) u_wrap_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (w_wrap_ev),
      .q   (wrap_count)
   );

   assign locked     = (r_state == LOCKED);
   assign wrap_pulse = r_wrap_pulse;
   assign err_pulse  = r_err_pulse;
   assign err_sticky = r_err_sticky;

endmodule
